seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
Round-robin scheduler that shares one serial sequence detector (single-bit `in`, active-low `rst_n`, single-bit `out`) among NREQ requesters. For each granted requester it:
- clears the detector,
- shifts in a WIDTH-bit word MSB-first,
- counts detector hits over the aligned window,
- returns the hit count with a done pulse.

It sits between the requesting blocks and the detector instance.

Parameters:
NREQ, 4, number of requesters (≥2)
WIDTH, 16, bits serialized per job
DET_LAT, 1, cycles from a bit driven on det_in to its effect on det_out (≥1)
CLR_CYC, 2, cycles det_rst_n is held low before each job (≥1)
CW, $clog2(WIDTH+1), hit-count width (derived, localparam)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
req  in  NREQ  level request per requester; held until gnt
req_data  in  NREQ*WIDTH  word for requester i at [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot, 1-cycle pulse; req_data sampled this cycle
done  out  NREQ  one-hot, 1-cycle pulse to job owner
hit_cnt  out  CW  hit count of last finished job; valid from done, held until next done
busy  out  1  high whenever state != IDLE
det_rst_n  out  1  detector reset, active-low
det_in  out  1  serial bit to detector
det_out  in  1  detector match output

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, done=0, busy=0, hit_cnt=0, det_rst_n=0, det_in=0, RR pointer so that req[0] has top priority. Takes effect in any state; an aborted job produces no done.
- In IDLE: det_rst_n=1, det_in=0.
- FSM states: IDLE -> CLEAR -> SHIFT -> DRAIN -> REPORT -> IDLE.
- IDLE, arbitration:
  - If any req is high in cycle T, grant the first requester at or after (last_granted+1) mod NREQ.
  - gnt[w]=1 combinationally in cycle T; latch req_data[w] into the shift register and w into owner.
  - Next state is CLEAR.
- CLEAR: CLR_CYC cycles (T+1..T+CLR_CYC); det_rst_n=0, det_in=0, hit counter cleared.
- SHIFT: WIDTH cycles; det_in = shreg[WIDTH-1]; shreg shifts left each cycle; det_rst_n=1.
- DRAIN: DET_LAT cycles; det_in=0.
- Counting window:
  - det_out is sampled at the edges closing cycles T+CLR_CYC+DET_LAT+1 .. T+CLR_CYC+WIDTH+DET_LAT (exactly WIDTH samples).
  - Each high sample increments the counter. Max is WIDTH, so no overflow.
  - det_out outside the window is ignored.
- REPORT: cycle T+CLR_CYC+WIDTH+DET_LAT+1.
  - done[owner]=1 and hit_cnt drives the final count in this same cycle; hit_cnt holds thereafter.
  - Next state is IDLE.
  - Grant-to-done latency = CLR_CYC+WIDTH+DET_LAT+1 cycles (20 at defaults).
- Back-to-back jobs: at least one IDLE cycle between REPORT and the next gnt.
- Requests:
  - req changes outside IDLE have no effect.
  - A requester that drops req before being granted is never granted.
  - Owner's req may stay high; it is re-arbitrated normally, with lowest priority next round.
- Every job starts from a cleared detector, so no hit can span two jobs.
- Outputs gnt and done are never high in the same cycle.

Test Plan:
(Bench detector model: overlapping "1011" detector, DET_LAT=1; defaults NREQ=4, WIDTH=16, CLR_CYC=2.)
1. Single job, req[1]=1 with req_data word1=0xB6DB -> gnt=0001<<1 at T; det_rst_n low T+1..T+2; det_in carries 1011011011011011 over T+3..T+18; done[1] at T+20 with hit_cnt=5; busy high T+1..T+20.
2. Zero and sparse patterns: word 0x0000 -> hit_cnt=0; word 0x0B0B -> hit_cnt=2; hit_cnt holds 2 while IDLE.
3. All four req held continuously, distinct data -> gnt order 0,1,2,3,0; one IDLE cycle between each done and next gnt; each done goes only to its owner.
4. Cross-job isolation: job A=0x0005, then job B=0x8000 from another requester -> both hit_cnt=0; the "101"+"1" boundary must not be counted.
5. Reset mid-SHIFT: rst=1 for one cycle at the 5th SHIFT cycle -> next cycle busy=0, det_rst_n=0, hit_cnt=0, no done. Then req[3] alone with 0xB000 -> granted first, hit_cnt=1.
6. Withdrawn request: req[2] pulsed only during a busy job and low at IDLE -> never granted; gnt stays 0.

Source files
------------

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that time-shares one serial sequence detector among NREQ requesters.
// Each granted job clears the detector, shifts a word MSB-first, and reports the hit count.
module seq_det_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int DET_LAT = 1,
  parameter int CLR_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               done,
  output logic [$clog2(WIDTH+1)-1:0]    hit_cnt,
  output logic                          busy,
  output logic                          det_rst_n,
  output logic                          det_in,
  input  logic                          det_out
);

  localparam int CW   = $clog2(WIDTH+1);
  localparam int IW   = $clog2(NREQ);
  localparam int PM0  = (WIDTH > CLR_CYC) ? WIDTH : CLR_CYC;
  localparam int PMAX = (PM0 > DET_LAT) ? PM0 : DET_LAT;
  localparam int PW   = $clog2(PMAX+1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    hit_q, hit_d;
  logic             det_rst_n_q, det_rst_n_d;
  logic             found_s;
  logic [IW-1:0]    win_s;
  logic [IW:0]      idx_s;

  // Search starts just after the last granted requester, wrapping around.
  always_comb begin
    found_s = 1'b0;
    win_s   = last_q;
    idx_s   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_s = {1'b0, last_q} + (IW+1)'(i);
      if (idx_s >= (IW+1)'(NREQ)) begin
        idx_s = idx_s - (IW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    shreg_d  = shreg_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    gnt      = '0;
    done     = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s && !rst) begin
          gnt[win_s] = 1'b1;
          shreg_d    = req_data[int'(win_s)*WIDTH +: WIDTH];
          owner_d    = win_s;
          last_d     = win_s;
          cyc_d      = '0;
          cnt_d      = '0;
          state_d    = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        if (cyc_q == PW'(CLR_CYC-1)) begin
          cyc_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cyc_d = cyc_q + PW'(1);
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        // The first DET_LAT shift cycles still show the detector's response to pre-job input.
        if ((cyc_q >= PW'(DET_LAT)) && det_out) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (cyc_q == PW'(WIDTH-1)) begin
          cyc_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cyc_d = cyc_q + PW'(1);
        end
      end
      S_DRAIN: begin
        if (det_out) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (cyc_q == PW'(DET_LAT-1)) begin
          cyc_d   = '0;
          state_d = S_REPORT;
        end else begin
          cyc_d = cyc_q + PW'(1);
        end
      end
      S_REPORT: begin
        done[owner_q] = 1'b1;
        hit_d         = cnt_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign det_rst_n_d = (state_d != S_CLEAR);
  assign det_rst_n   = det_rst_n_q;
  assign det_in      = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign busy        = (state_q != S_IDLE);
  assign hit_cnt     = (state_q == S_REPORT) ? cnt_q : hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      shreg_q     <= '0;
      owner_q     <= '0;
      last_q      <= IW'(NREQ-1);
      cnt_q       <= '0;
      hit_q       <= '0;
      det_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      shreg_q     <= shreg_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      det_rst_n_q <= det_rst_n_d;
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: overlapping "1011" detector stand-in plus a job-timeline reference model
// that predicts gnt/done/busy/hit_cnt/det_* every cycle from arbitration and pattern-counting rules.
module tb_seq_det_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int CLR  = 2;
  localparam int DLAT = 1;
  localparam int LAT  = CLR + W + DLAT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [4:0]        hit_cnt;
  logic              busy;
  logic              det_rst_n;
  logic              det_in;
  logic              det_out = 1'b0;
  logic [2:0]        det_hist = 3'b000;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: one job timeline measured in cycles since grant.
  bit        m_active    = 1'b0;
  int        m_age       = 0;
  int        m_owner     = 0;
  logic [15:0] m_word    = 16'h0000;
  int        m_last      = NREQ - 1;
  int        m_hit       = 0;
  bit        m_after_rst = 1'b0;

  seq_det_sched #(.NREQ(NREQ), .WIDTH(W), .DET_LAT(DLAT), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .hit_cnt(hit_cnt), .busy(busy), .det_rst_n(det_rst_n), .det_in(det_in), .det_out(det_out)
  );

  always #5 clk = ~clk;

  // Overlapping "1011" detector with one cycle of latency.
  always @(posedge clk) begin
    if (!det_rst_n) begin
      det_hist <= 3'b000;
      det_out  <= 1'b0;
    end else begin
      det_hist <= {det_hist[1:0], det_in};
      det_out  <= ({det_hist, det_in} == 4'b1011);
    end
  end

  function automatic int count_1011(logic [15:0] w);
    int c = 0;
    for (int j = 0; j <= W - 4; j++) begin
      if (w[j +: 4] == 4'b1011) c++;
    end
    return c;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_cycle();
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_done;
    logic e_busy, e_rstn, e_in;
    int gw;
    @(negedge clk);
    e_gnt = '0; e_done = '0; e_busy = m_active; e_rstn = 1'b1; e_in = 1'b0; gw = -1;
    if (!m_active) begin
      for (int i = 1; i <= NREQ; i++) begin
        if (gw < 0 && req[(m_last + i) % NREQ]) gw = (m_last + i) % NREQ;
      end
      if (gw >= 0) e_gnt[gw] = 1'b1;
    end else begin
      if (m_age <= CLR) e_rstn = 1'b0;
      else if (m_age <= CLR + W) e_in = m_word[W - 1 - (m_age - CLR - 1)];
      if (m_age == LAT) begin
        e_done[m_owner] = 1'b1;
        m_hit = count_1011(m_word);
      end
    end
    if (m_after_rst) e_rstn = 1'b0;
    if (!rst) begin
      chk("gnt", gnt, e_gnt);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("hit_cnt", hit_cnt, m_hit);
      chk("det_rst_n", det_rst_n, e_rstn);
      chk("det_in", det_in, e_in);
    end
    m_after_rst = 1'b0;
    if (m_active) begin
      if (m_age == LAT) m_active = 1'b0;
      else m_age++;
    end
    if (gw >= 0) begin
      m_active = 1'b1;
      m_age    = 1;
      m_owner  = gw;
      m_word   = req_data[gw*W +: W];
      m_last   = gw;
    end
    if (rst) begin
      m_active = 1'b0; m_hit = 0; m_last = NREQ - 1; m_after_rst = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  task automatic job(int idx, logic [15:0] word);
    req_data[idx*W +: W] = word;
    req = NREQ'(1 << idx);
    run_cycle();
    req = '0;
    repeat (LAT) run_cycle();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    repeat (2) run_cycle();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_det_rst_n", det_rst_n, 0);
    chk("rst_gnt", gnt, 0);
    run_cycle();

    // 1: single job, five overlapping hits
    job(1, 16'hB6DB);
    chk("t1_hit", hit_cnt, 5);

    // 2: zero and sparse words; count held while idle
    job(0, 16'h0000);
    chk("t2_zero", hit_cnt, 0);
    job(2, 16'h0B0B);
    repeat (3) run_cycle();
    chk("t2_hold", hit_cnt, 2);

    // 3: all requesters held, round-robin from a fresh reset
    do_reset();
    req_data = {16'hBBBB, 16'h0B00, 16'hB0B0, 16'h1011};
    req = 4'hF;
    repeat (5 * (LAT + 1)) run_cycle();
    req = '0;
    repeat (LAT + 2) run_cycle();

    // 4: no hit may straddle two jobs
    job(1, 16'h0005);
    chk("t4_a", hit_cnt, 0);
    job(3, 16'h8000);
    chk("t4_b", hit_cnt, 0);

    // 5: reset in the middle of SHIFT aborts the job
    req_data[0 +: W] = 16'hB6DB;
    req = 4'b0001;
    run_cycle();
    req = '0;
    repeat (CLR + 4) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_det_rst_n", det_rst_n, 0);
    chk("t5_hit", hit_cnt, 0);
    repeat (LAT) run_cycle();
    job(3, 16'hB000);
    chk("t5_hit_after", hit_cnt, 1);

    // 6: request raised only while busy is never granted
    req_data[0 +: W] = 16'h00B0;
    req = 4'b0001;
    run_cycle();
    req = 4'b0100;
    repeat (10) run_cycle();
    req = '0;
    repeat (LAT - 10 + 3) run_cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_data = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) req_data[$urandom_range(0, 3)*W +: W] = 16'hBBBB;
      run_cycle();
    end
    req = '0;
    repeat (LAT + 2) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
